// File: rtl/lpddr2_responder.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : lpddr2_responder
//  Purpose  : Responder for the CPU LPDDR2 request interface. Turns each
//             level-held read/write request into exactly one Avalon-MM
//             transaction on the LPDDR2 controller local port, returns read
//             data, and holds the CPU in stall until the access completes.
//             A one-entry write-through read cache absorbs repeated reads of
//             the same word.
//
//  Ports
//    clk, rst_n         : single clock; asynchronous active-low reset
//    address            : word address from the master
//    write_data         : write data from the master
//    read_req/write_req : level requests (write wins when both are high)
//    read_data          : cached read result (valid whenever stall = 0)
//    stall              : CPU freeze; access completes when a request is
//                         present and stall = 0
//    err                : sticky read-timeout flag
//    avl_*              : Avalon-MM local port of the LPDDR2 controller
//
//  Revision : 1.0  initial release
// ============================================================================
module lpddr2_responder #(
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    // CPU memory master side
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_req,
    input  logic              write_req,
    output logic [DATA_W-1:0] read_data,
    output logic              stall,
    output logic              err,
    // LPDDR2 controller local port
    input  logic              avl_init_done,
    output logic [ADDR_W-1:0] avl_address,
    output logic              avl_read,
    output logic              avl_write,
    output logic [DATA_W-1:0] avl_writedata,
    input  logic [DATA_W-1:0] avl_readdata,
    input  logic              avl_readdatavalid,
    input  logic              avl_waitrequest
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_WR_ISSUE = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_stall;
    logic              w_req;
    logic              w_hit;
    logic              w_timeout;
    logic              w_wr_accept;

    logic              r_cache_valid;
    logic [ADDR_W-1:0] r_cache_addr;
    logic [DATA_W-1:0] r_cache_data;
    logic [CNT_W-1:0]  r_tmo_cnt;
    logic              r_err;
    logic              r_avl_read;
    logic              r_avl_write;
    logic [ADDR_W-1:0] r_avl_address;
    logic [DATA_W-1:0] r_avl_writedata;

    assign w_req       = read_req | write_req;
    assign w_hit       = r_cache_valid && (r_cache_addr == address);
    // Counter is zero in the first RD_WAIT cycle, so this fires in the
    // TIMEOUT-th cycle spent waiting for read data.
    assign w_timeout   = (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign w_wr_accept = (r_state == ST_WR_ISSUE) && !avl_waitrequest;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and stall
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_stall = w_req;
                if (avl_init_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // Only a clean read hit completes without a controller access.
                w_stall = write_req | (read_req & ~w_hit);
                if (write_req) begin
                    w_state_next = ST_WR_ISSUE;
                end else if (read_req && !w_hit) begin
                    w_state_next = ST_RD_ISSUE;
                end
            end
            ST_WR_ISSUE: begin
                w_stall = w_req;
                if (!avl_waitrequest) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_RD_ISSUE: begin
                w_stall = w_req;
                if (!avl_waitrequest) begin
                    w_state_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                w_stall = w_req;
                if (avl_readdatavalid || w_timeout) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Release the CPU for one cycle; the still-present request
                // is deliberately not re-examined here.
                w_stall      = 1'b0;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_stall      = w_req;
                w_state_next = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Controller strobes and latched request
    // Strobes are registered from the next state so each is high exactly
    // for the cycles spent in its issue state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_avl_read      <= 1'b0;
            r_avl_write     <= 1'b0;
            r_avl_address   <= '0;
            r_avl_writedata <= '0;
        end else begin
            r_avl_read  <= (w_state_next == ST_RD_ISSUE);
            r_avl_write <= (w_state_next == ST_WR_ISSUE);
            if ((r_state == ST_IDLE) && (w_state_next != ST_IDLE)) begin
                r_avl_address <= address;
                if (write_req) begin
                    r_avl_writedata <= write_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-wait timeout counter: held at zero outside RD_WAIT so it is
    // already clear on entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_RD_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // One-entry cache and sticky error
    // Writes update the entry (write-through) so a read of the same word
    // right after a write hits. A timed-out read invalidates the entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cache_valid <= 1'b0;
            r_cache_addr  <= '0;
            r_cache_data  <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_cache_valid <= 1'b1;
                r_cache_addr  <= r_avl_address;
                r_cache_data  <= r_avl_writedata;
            end else if (r_state == ST_RD_WAIT) begin
                if (avl_readdatavalid) begin
                    r_cache_valid <= 1'b1;
                    r_cache_addr  <= r_avl_address;
                    r_cache_data  <= avl_readdata;
                end else if (w_timeout) begin
                    r_cache_valid <= 1'b0;
                    r_cache_data  <= '0;
                    r_err         <= 1'b1;
                end
            end
        end
    end

    assign read_data     = r_cache_data;
    assign stall         = w_stall;
    assign err           = r_err;
    assign avl_address   = r_avl_address;
    assign avl_read      = r_avl_read;
    assign avl_write     = r_avl_write;
    assign avl_writedata = r_avl_writedata;

endmodule
`default_nettype wire

// File: tb/tb_lpddr2_responder.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_lpddr2_responder
//  Purpose  : Self-checking bench for lpddr2_responder. A controller model
//             with a word memory answers the Avalon port; a cache/memory
//             model predicts stall length, transaction counts and data.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lpddr2_responder;

    localparam int ADDR_W  = 27;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 1023;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              read_req;
    logic              write_req;
    logic [DATA_W-1:0] read_data;
    logic              stall;
    logic              err;
    logic              avl_init_done;
    logic [ADDR_W-1:0] avl_address;
    logic              avl_read;
    logic              avl_write;
    logic [DATA_W-1:0] avl_writedata;
    logic [DATA_W-1:0] avl_readdata;
    logic              avl_readdatavalid;
    logic              avl_waitrequest;

    always #5 clk = ~clk;

    lpddr2_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .address          (address),
        .write_data       (write_data),
        .read_req         (read_req),
        .write_req        (write_req),
        .read_data        (read_data),
        .stall            (stall),
        .err              (err),
        .avl_init_done    (avl_init_done),
        .avl_address      (avl_address),
        .avl_read         (avl_read),
        .avl_write        (avl_write),
        .avl_writedata    (avl_writedata),
        .avl_readdata     (avl_readdata),
        .avl_readdatavalid(avl_readdatavalid),
        .avl_waitrequest  (avl_waitrequest)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Controller model
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    int                cfg_wait, cfg_lat;
    bit                cfg_drop, cfg_spur;
    int                wait_left, rd_cnt;
    bit                rd_pending;
    logic [DATA_W-1:0] rd_val;
    int                n_rd, n_wr;
    logic [ADDR_W-1:0] last_rd_addr, last_wr_addr;
    logic [DATA_W-1:0] last_wr_data;

    // Responder model: one cached word plus sticky error
    bit                mc_valid;
    logic [ADDR_W-1:0] mc_addr;
    logic [DATA_W-1:0] mc_data;
    bit                m_err;

    logic [ADDR_W-1:0] addr_tbl [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mem_value(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        if (mem.exists(a)) v = mem[a];
        else               v = {a[15:0], ~a[15:0]};
        return v;
    endfunction

    task automatic ctl_reset();
        wait_left         = cfg_wait;
        rd_pending        = 1'b0;
        rd_cnt            = 0;
        avl_readdatavalid = 1'b0;
        avl_waitrequest   = 1'b0;
    endtask

    // Controller behaviour for the coming rising edge; called at negedge.
    task automatic ctl_step();
        avl_readdatavalid = 1'b0;
        avl_readdata      = $urandom;
        if (rd_pending && !cfg_drop && rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                avl_readdatavalid = 1'b1;
                avl_readdata      = rd_val;
                rd_pending        = 1'b0;
            end
        end else if (!rd_pending && cfg_spur && $urandom_range(0, 3) == 0) begin
            avl_readdatavalid = 1'b1;
        end
        if (avl_read || avl_write) begin
            if (wait_left > 0) begin
                avl_waitrequest = 1'b1;
                wait_left--;
            end else begin
                avl_waitrequest = 1'b0;
                wait_left       = cfg_wait;
                if (avl_write) begin
                    n_wr++;
                    last_wr_addr     = avl_address;
                    last_wr_data     = avl_writedata;
                    mem[avl_address] = avl_writedata;
                end else begin
                    n_rd++;
                    last_rd_addr = avl_address;
                    rd_pending   = 1'b1;
                    rd_cnt       = cfg_lat;
                    rd_val       = mem_value(avl_address);
                end
            end
        end else begin
            avl_waitrequest = cfg_spur ? 1'($urandom_range(0, 1)) : 1'b0;
            wait_left       = cfg_wait;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        ctl_step();
    endtask

    // kind: 0 read, 1 write, 2 read+write. extra: cycles spent in INIT first.
    task automatic do_access(input int kind, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input int wt, input int lat,
                             input bit drop, input int extra, input bit keep,
                             input bit scramble);
        bit                hit;
        int                exp_ticks, ticks, rd0, wr0;
        logic [DATA_W-1:0] exp_data;
        cfg_wait  = wt;
        cfg_lat   = lat;
        cfg_drop  = drop;
        wait_left = wt;
        hit = (kind == 0) && mc_valid && (mc_addr == a);
        if (kind != 0)    exp_ticks = wt + 2;
        else if (hit)     exp_ticks = 0;
        else if (drop)    exp_ticks = wt + TIMEOUT + 2;
        else              exp_ticks = wt + lat + 2;
        exp_ticks += extra;
        rd0 = n_rd;
        wr0 = n_wr;
        address    = a;
        write_data = d;
        read_req   = (kind != 1);
        write_req  = (kind != 0);
        #1;
        ticks = 0;
        while (stall && ticks < exp_ticks + 50) begin
            tick();
            ticks++;
            if (scramble && stall) begin
                address    = ADDR_W'($urandom);
                write_data = $urandom;
            end
            #1;
        end
        check("stall_cycles", 64'(ticks), 64'(exp_ticks));
        if (kind != 0) begin
            mc_valid = 1'b1;
            mc_addr  = a;
            mc_data  = d;
            exp_data = d;
            check("wr_count", 64'(n_wr - wr0), 64'd1);
            check("wr_addr", 64'(last_wr_addr), 64'(a));
            check("wr_data", 64'(last_wr_data), 64'(d));
            check("rd_count_on_write", 64'(n_rd - rd0), 64'd0);
        end else if (hit) begin
            exp_data = mc_data;
            check("rd_count_hit", 64'(n_rd - rd0), 64'd0);
        end else begin
            check("rd_count_miss", 64'(n_rd - rd0), 64'd1);
            check("rd_addr", 64'(last_rd_addr), 64'(a));
            if (drop) begin
                mc_valid = 1'b0;
                mc_data  = '0;
                m_err    = 1'b1;
            end else begin
                mc_valid = 1'b1;
                mc_addr  = a;
                mc_data  = mem_value(a);
            end
            exp_data = mc_data;
        end
        check("read_data", 64'(read_data), 64'(exp_data));
        check("err", 64'(err), 64'(m_err));
        if (!keep) begin
            read_req  = 1'b0;
            write_req = 1'b0;
            tick();
        end
        if (drop) begin
            cfg_drop   = 1'b0;
            rd_pending = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] ra;
        int                k;
        addr_tbl[0] = 27'h0000010;
        addr_tbl[1] = 27'h0000011;
        addr_tbl[2] = 27'h0000800;
        addr_tbl[3] = 27'h1234567;

        rst_n         = 1'b0;
        avl_init_done = 1'b0;
        address       = '0;
        write_data    = '0;
        read_req      = 1'b0;
        write_req     = 1'b0;
        avl_readdata  = '0;
        cfg_wait = 0; cfg_lat = 1; cfg_drop = 0; cfg_spur = 0;
        n_rd = 0; n_wr = 0;
        mc_valid = 0; mc_addr = '0; mc_data = '0; m_err = 0;
        ctl_reset();

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_read_data", 64'(read_data), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_strobes", 64'({avl_read, avl_write}), 64'd0);
        check("rst_avl_address", 64'(avl_address), 64'd0);
        check("rst_avl_writedata", 64'(avl_writedata), 64'd0);
        rst_n = 1'b1;

        // Calibration not done: request must wait in INIT
        read_req = 1'b1;
        address  = 27'h0000040;
        #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            check("init_stall", 64'(stall), 64'd1);
            check("init_no_read", 64'(avl_read), 64'd0);
        end
        avl_init_done = 1'b1;
        do_access(0, 27'h0000040, '0, 1, 3, 0, 1, 0, 0);

        // Write with three waitrequest cycles, then a read hit
        do_access(1, 27'h0000800, 32'hA5A5_1234, 3, 1, 0, 0, 0, 0);
        do_access(0, 27'h0000800, '0, 0, 1, 0, 0, 0, 0);
        check("hit_data", 64'(read_data), 64'hA5A5_1234);

        // Read miss with 7-cycle latency, request held for 20 more cycles
        mem[27'h1234567] = 32'hCAFE_BABE;
        do_access(0, 27'h1234567, '0, 0, 7, 0, 0, 1, 0);
        k = n_rd;
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            check("held_read_stall", 64'(stall), 64'd0);
        end
        check("held_read_count", 64'(n_rd - k), 64'd0);
        check("held_read_data", 64'(read_data), 64'hCAFE_BABE);
        read_req = 1'b0;
        tick();

        // Both requests: write wins
        do_access(2, 27'h0000900, 32'h1122_3344, 1, 1, 0, 0, 0, 0);

        // Read timeout, then re-issue of the same address
        do_access(0, 27'h0000555, '0, 0, 1, 1, 0, 0, 0);
        do_access(0, 27'h0000555, '0, 0, 2, 0, 0, 0, 0);

        // Randomized mix with in-flight address/data changes and noise
        cfg_spur = 1'b1;
        for (int i = 0; i < 60; i++) begin
            ra = addr_tbl[$urandom_range(0, 3)];
            k  = $urandom_range(0, 3);
            do_access((k == 3) ? 2 : ((k == 2) ? 1 : 0), ra, $urandom,
                      $urandom_range(0, 3), $urandom_range(1, 9), 0, 0, 0, 1);
        end
        cfg_spur = 1'b0;
        ctl_reset();

        // Reset asserted while a read is in RD_ISSUE
        cfg_wait  = 5;
        wait_left = 5;
        ra        = mc_valid ? mc_addr : 27'h0000010;
        read_req  = 1'b1;
        address   = 27'h0007777;
        tick();
        #1;
        check("issue_read_high", 64'(avl_read), 64'd1);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_read_low", 64'(avl_read), 64'd0);
        check("arst_err", 64'(err), 64'd0);
        check("arst_read_data", 64'(read_data), 64'd0);
        check("arst_stall_init", 64'(stall), 64'd1);
        read_req = 1'b0;
        cfg_wait = 0;
        ctl_reset();
        mc_valid = 1'b0;
        mc_data  = '0;
        m_err    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Previously cached word must miss after reset
        do_access(0, ra, '0, 0, 2, 0, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
